mul_div_unit: RTL and testbench

Iterative 32-bit unsigned multiply/divide unit for the single-cycle processor datapath. It sits directly downstream of the operand-B select mux. That mux supplies either a 32-bit register operand or a zero-extended 9-bit immediate. The unit consumes the selected operand with operand A, runs a fixed 32-iteration shift-add or restoring-divide sequence, and returns a 32-bit result with a start/busy/done handshake. The control unit stalls the PC while `busy` is high.

---
 rtl/mul_div_unit.sv | 118 +++++++++++
 tb/tb_mul_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: 32-step shift-add multiply and
// restoring divide behind a start/busy/done handshake.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Data_a,
    input  logic [WIDTH-1:0] Data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [WIDTH-1:0] opnd;
    // {hi, lo}: product accumulator, or {remainder, quotient/dividend}.
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             keep;

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        nxt_hi  = hi;
        nxt_lo  = lo;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        shifted = {hi, lo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        // A non-negative difference is always below the divisor, so both top bits are clear.
        keep    = (diff[WIDTH+1:WIDTH] == 2'b00);
        if (op_q[1]) begin
            if (keep) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // Control FSM, operand capture, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op_q   <= 2'b00;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_q  <= op;
                        cnt   <= '0;
                        hi    <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                        if (op[1]) begin
                            lo   <= Data_a;
                            opnd <= Data_b;
                        end else begin
                            lo   <= Data_b;
                            opnd <= Data_a;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        // MULHU and REMU take the upper half; MUL and DIVU the lower.
                        result <= op_q[0] ? nxt_hi : nxt_lo;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  op     = 2'b00;
    logic [31:0] data_a = 32'h0;
    logic [31:0] data_b = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .Data_a (data_a),
        .Data_b (data_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count negedges with busy high (bounded), noting any overlap with done.
    task automatic count_busy(output int n, output logic overlap);
        n = 0;
        overlap = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (done !== 1'b0) overlap = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    // Launch one operation from idle and check latency, pulse and result.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int   n;
        logic ov;
        @(negedge clk);
        start = 1'b1; op = o; data_a = a; data_b = b;
        @(negedge clk);
        start = 1'b0;
        count_busy(n, ov);
        check({tag, " busy cycles"}, 32'(n), 32'd32);
        check({tag, " busy/done overlap"}, {31'b0, ov}, 32'd0);
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " result"}, result, exp);
        @(negedge clk);
        check({tag, " done width"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int   n;
        int   seen;
        logic ov;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'h0);
        rst_n = 1'b1;

        // Basic multiply and the all-ones product
        do_op("mul 7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A);
        do_op("mulhu ff*ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("mul ff*ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // Immediate-style operand B
        do_op("mul imm", 2'b00, 32'h00000400, 32'h000001FF, 32'h0007FC00);
        do_op("divu imm", 2'b10, 32'h00000400, 32'h000001FF, 32'h00000002);
        do_op("remu imm", 2'b11, 32'h00000400, 32'h000001FF, 32'h00000002);
        do_op("divu 1000/7", 2'b10, 32'd1000, 32'd7, 32'h0000008E);
        do_op("remu 1000/7", 2'b11, 32'd1000, 32'd7, 32'h00000006);

        // Divide by zero
        do_op("divu by 0", 2'b10, 32'h00001234, 32'h0, 32'hFFFFFFFF);
        do_op("remu by 0", 2'b11, 32'h00001234, 32'h0, 32'h00001234);

        // start and operands disturbed mid-run are ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; data_a = 32'd7; data_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b10; data_a = 32'd100; data_b = 32'd3;
        repeat (10) @(negedge clk);
        start = 1'b0;
        count_busy(n, ov);
        check("midrun busy cycles", 32'(n + 15), 32'd32);
        check("midrun done", {31'b0, done}, 32'd1);
        check("midrun result", result, 32'h0000002A);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("midrun no extra op", 32'(seen), 32'd0);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        start = 1'b1; op = 2'b00; data_a = 32'd2; data_b = 32'd3;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("b2b first done", {31'b0, done}, 32'd1);
        check("b2b first result", result, 32'h00000006);
        op = 2'b10; data_a = 32'd100; data_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("b2b contiguous busy", {31'b0, busy}, 32'd1);
        check("b2b done dropped", {31'b0, done}, 32'd0);
        count_busy(n, ov);
        check("b2b busy cycles", 32'(n), 32'd32);
        check("b2b second done", {31'b0, done}, 32'd1);
        check("b2b second result", result, 32'h0000000E);
        @(negedge clk);

        // Reset during iteration 10
        start = 1'b1; op = 2'b00; data_a = 32'd9; data_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort result", result, 32'h0);
        rst_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);
        do_op("mul 3x5 after reset", 2'b00, 32'd3, 32'd5, 32'h0000000F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
